// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants and the
// clocks-per-bit calculation used by both the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Rounded to the nearest whole clock so the bit-period error stays below half a clock.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter; full/empty are decoded
// from the occupancy count so the pointers can wrap freely.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter: buffered valid/ready input, LSB-first framing with
// optional parity and one or two stop bits, back-to-back frames when words are queued.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 2,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_core: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_core: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_core: PARITY must be 0, 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_core: CLK_FREQ/BAUD must give at least 2 clocks per bit");
    end

    uart_state_t            state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_head;
    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic                   last_stop;
    logic                   word_par;

    assign tx_ready  = !fifo_full;
    assign push      = tx_valid && !fifo_full;
    assign bit_end   = (baud_cnt == CNT_LAST);
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    assign word_par  = (PARITY == PARITY_ODD) ? ~^fifo_head : ^fifo_head;
    assign busy      = (state != S_IDLE) || (fifo_count != '0);

    // The head is taken either from idle or on the very last stop-bit clock, which
    // is what lets queued frames follow each other with no idle gap.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) || (state == S_STOP && bit_end && last_stop));

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (tx_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_out   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_out   <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shreg   <= fifo_head;
                        par_bit <= word_par;
                        tx_out  <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_out   <= shreg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY != PARITY_NONE) begin
                                tx_out <= par_bit;
                                state  <= S_PARITY;
                            end else begin
                                tx_out   <= 1'b1;
                                stop_idx <= 1'b0;
                                state    <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            tx_out  <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_out   <= 1'b1;
                        stop_idx <= 1'b0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!last_stop) begin
                            stop_idx <= 1'b1;
                        end else if (pop) begin
                            shreg   <= fifo_head;
                            par_bit <= word_par;
                            tx_out  <= 1'b0;
                            state   <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_out   <= 1'b1;
                    baud_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: four instances cover 8E1 at full baud divisor,
// 7O2, 8E1 with a short divisor for FIFO corner cases, and 5N1.
module tb_uart_tx_core;

    localparam int DIV_A = 1667;
    localparam int DIV_B = 8;
    localparam int DIV_C = 4;
    localparam int DIV_D = 4;

    logic       clk;
    logic       rst;
    logic       valid_u [4];
    logic [8:0] data_u  [4];
    logic       ready_u [4];
    logic       tx_u    [4];
    logic       busy_u  [4];
    logic [2:0] count_u [4];

    int checks;
    int errors;

    typedef struct {
        int          unit;
        logic [8:0]  data;
        int          nbits;
        int          div;
        logic [15:0] line;
    } vec_t;

    vec_t       vecs [10];
    logic [8:0] words [5];
    logic [2:0] exp_counts [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_core u_dut_a (
        .clk(clk), .rst(rst), .tx_valid(valid_u[0]), .tx_data(data_u[0][7:0]),
        .tx_ready(ready_u[0]), .tx_out(tx_u[0]), .busy(busy_u[0]), .fifo_count(count_u[0])
    );

    uart_tx_core #(
        .CLK_FREQ(16), .BAUD(2), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .tx_valid(valid_u[1]), .tx_data(data_u[1][6:0]),
        .tx_ready(ready_u[1]), .tx_out(tx_u[1]), .busy(busy_u[1]), .fifo_count(count_u[1])
    );

    uart_tx_core #(
        .CLK_FREQ(40), .BAUD(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_c (
        .clk(clk), .rst(rst), .tx_valid(valid_u[2]), .tx_data(data_u[2][7:0]),
        .tx_ready(ready_u[2]), .tx_out(tx_u[2]), .busy(busy_u[2]), .fifo_count(count_u[2])
    );

    uart_tx_core #(
        .CLK_FREQ(40), .BAUD(10), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_d (
        .clk(clk), .rst(rst), .tx_valid(valid_u[3]), .tx_data(data_u[3][4:0]),
        .tx_ready(ready_u[3]), .tx_out(tx_u[3]), .busy(busy_u[3]), .fifo_count(count_u[3])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int unit, input logic [8:0] data);
        valid_u[unit] = 1'b1;
        data_u[unit]  = data;
        @(negedge clk);
        valid_u[unit] = 1'b0;
    endtask

    // Line image is time-ordered from the MSB end: bit nbits-1 is the start bit.
    function automatic logic [15:0] frame8e1(input logic [7:0] w);
        logic [15:0] f;
        f     = '0;
        f[10] = 1'b0;
        for (int i = 0; i < 8; i++) f[9-i] = w[i];
        f[1]  = ^w;
        f[0]  = 1'b1;
        return f;
    endfunction

    task automatic checkFrame(input int unit, input logic [15:0] line, input int nbits,
                              input int div, input int start_k, input string name);
        logic expv;
        logic seen;
        bit   bad;
        bit   any;
        int   k;
        for (int i = 0; i < nbits; i++) begin
            expv = line[nbits-1-i];
            seen = expv;
            bad  = 1'b0;
            any  = 1'b0;
            for (int c = 0; c < div; c++) begin
                k = i * div + c;
                if (k >= start_k) begin
                    if (k > start_k) @(negedge clk);
                    any = 1'b1;
                    if (tx_u[unit] !== expv && !bad) begin
                        bad  = 1'b1;
                        seen = tx_u[unit];
                    end
                end
            end
            if (any) checkOutput($sformatf("%s_bit%0d", name, i), 32'(seen), 32'(expv));
        end
    endtask

    task automatic pushFive(input int unit, input string name);
        for (int j = 0; j < 5; j++) begin
            valid_u[unit] = 1'b1;
            data_u[unit]  = words[j];
            @(negedge clk);
            checkOutput($sformatf("%s_count_push%0d", name, j), 32'(count_u[unit]), 32'(exp_counts[j]));
        end
        valid_u[unit] = 1'b0;
        checkOutput($sformatf("%s_ready_full", name), 32'(ready_u[unit]), 32'd0);
    endtask

    initial begin
        bit   bad;
        logic [8:0] w6;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        for (int u = 0; u < 4; u++) begin
            valid_u[u] = 1'b0;
            data_u[u]  = '0;
        end
        exp_counts[0] = 3'd1; exp_counts[1] = 3'd1; exp_counts[2] = 3'd2;
        exp_counts[3] = 3'd3; exp_counts[4] = 3'd4;

        vecs[0] = '{0, 9'h0A5, 11, DIV_A, 16'b01010010101};
        vecs[1] = '{1, 9'h003, 11, DIV_B, 16'b01100000111};
        vecs[2] = '{1, 9'h07F, 11, DIV_B, 16'b01111111011};
        vecs[3] = '{1, 9'h000, 11, DIV_B, 16'b00000000111};
        vecs[4] = '{2, 9'h000, 11, DIV_C, 16'b00000000001};
        vecs[5] = '{2, 9'h0FF, 11, DIV_C, 16'b01111111101};
        vecs[6] = '{2, 9'h001, 11, DIV_C, 16'b01000000011};
        vecs[7] = '{2, 9'h080, 11, DIV_C, 16'b00000000111};
        vecs[8] = '{3, 9'h01F, 7,  DIV_D, 16'b0111111};
        vecs[9] = '{3, 9'h00A, 7,  DIV_D, 16'b0010101};

        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            checkOutput($sformatf("reset_tx_u%0d", u),    32'(tx_u[u]),    32'd1);
            checkOutput($sformatf("reset_busy_u%0d", u),  32'(busy_u[u]),  32'd0);
            checkOutput($sformatf("reset_ready_u%0d", u), 32'(ready_u[u]), 32'd1);
            checkOutput($sformatf("reset_count_u%0d", u), 32'(count_u[u]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Single frames from idle: latency, every bit period, and busy release.
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].unit, vecs[v].data);
            checkOutput($sformatf("v%0d_line_before_start", v), 32'(tx_u[vecs[v].unit]), 32'd1);
            checkOutput($sformatf("v%0d_busy_queued", v), 32'(busy_u[vecs[v].unit]), 32'd1);
            @(negedge clk);
            checkFrame(vecs[v].unit, vecs[v].line, vecs[v].nbits, vecs[v].div, 0, $sformatf("v%0d", v));
            checkOutput($sformatf("v%0d_busy_last", v), 32'(busy_u[vecs[v].unit]), 32'd1);
            @(negedge clk);
            checkOutput($sformatf("v%0d_busy_done", v),  32'(busy_u[vecs[v].unit]),  32'd0);
            checkOutput($sformatf("v%0d_tx_idle", v),    32'(tx_u[vecs[v].unit]),    32'd1);
            checkOutput($sformatf("v%0d_ready_idle", v), 32'(ready_u[vecs[v].unit]), 32'd1);
            repeat (2) @(negedge clk);
        end

        // Five words back-to-back: FIFO fills, frames abut, count steps down.
        words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033; words[3] = 9'h044; words[4] = 9'h055;
        pushFive(2, "t3");
        checkFrame(2, frame8e1(words[0][7:0]), 11, DIV_C, 3, "t3_f0");
        for (int j = 1; j < 5; j++) begin
            @(negedge clk);
            checkOutput($sformatf("t3_count_f%0d", j), 32'(count_u[2]), 32'(4 - j));
            checkFrame(2, frame8e1(words[j][7:0]), 11, DIV_C, 0, $sformatf("t3_f%0d", j));
        end
        @(negedge clk);
        checkOutput("t3_busy_done", 32'(busy_u[2]), 32'd0);
        repeat (3) @(negedge clk);

        // Full FIFO with a push held across the pop: ready returns one cycle later.
        words[0] = 9'h05A; words[1] = 9'h0C3; words[2] = 9'h00F; words[3] = 9'h0F0; words[4] = 9'h096;
        w6 = 9'h03C;
        pushFive(2, "t4");
        valid_u[2] = 1'b1;
        data_u[2]  = w6;
        repeat (40) @(negedge clk);
        checkOutput("t4_ready_popcycle", 32'(ready_u[2]), 32'd0);
        checkOutput("t4_count_popcycle", 32'(count_u[2]), 32'd4);
        @(negedge clk);
        checkOutput("t4_ready_after_pop", 32'(ready_u[2]), 32'd1);
        checkOutput("t4_count_after_pop", 32'(count_u[2]), 32'd3);
        @(negedge clk);
        checkOutput("t4_ready_refull", 32'(ready_u[2]), 32'd0);
        checkOutput("t4_count_refull", 32'(count_u[2]), 32'd4);
        valid_u[2] = 1'b0;
        checkFrame(2, frame8e1(words[1][7:0]), 11, DIV_C, 1, "t4_f1");
        for (int j = 2; j < 6; j++) begin
            @(negedge clk);
            checkOutput($sformatf("t4_count_f%0d", j), 32'(count_u[2]), 32'(5 - j));
            checkFrame(2, frame8e1((j < 5) ? words[j][7:0] : w6[7:0]), 11, DIV_C, 0, $sformatf("t4_f%0d", j));
        end
        @(negedge clk);
        checkOutput("t4_busy_done", 32'(busy_u[2]), 32'd0);
        repeat (3) @(negedge clk);

        // Reset in the middle of frame 2's data bits with two words still queued.
        for (int j = 0; j < 4; j++) begin
            valid_u[2] = 1'b1;
            data_u[2]  = 9'h000;
            @(negedge clk);
        end
        valid_u[2] = 1'b0;
        repeat (54) @(negedge clk);
        checkOutput("t5_mid_line", 32'(tx_u[2]),    32'd0);
        checkOutput("t5_mid_count", 32'(count_u[2]), 32'd2);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_tx",    32'(tx_u[2]),    32'd1);
        checkOutput("t5_rst_busy",  32'(busy_u[2]),  32'd0);
        checkOutput("t5_rst_count", 32'(count_u[2]), 32'd0);
        checkOutput("t5_rst_ready", 32'(ready_u[2]), 32'd1);
        rst = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_u[2] !== 1'b1 || busy_u[2] !== 1'b0) bad = 1'b1;
        end
        checkOutput("t5_no_stale_frame", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
